// File: rtl/cpack_dict_decoder.sv
// Decompressor dictionary controller: rebuilds two words per beat from code/index/literal
// triples and maintains a FIFO dictionary that mirrors the compressor's.
module cpack_dict_decoder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_code0,
  input  logic [2:0]       i_code1,
  input  logic [IDX_W-1:0] i_idx0,
  input  logic [IDX_W-1:0] i_idx1,
  input  logic [31:0]      i_lit0,
  input  logic [31:0]      i_lit1,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_word0,
  output logic [31:0]      o_word1,
  output logic [IDX_W-1:0] o_wr_ptr,
  output logic             o_err
);

  localparam logic [2:0] C_ZZZZ = 3'd0;
  localparam logic [2:0] C_XXXX = 3'd1;
  localparam logic [2:0] C_MMMM = 3'd2;
  localparam logic [2:0] C_MMXX = 3'd3;
  localparam logic [2:0] C_ZZZX = 3'd4;
  localparam logic [2:0] C_MMMX = 3'd5;

  logic [31:0]      dict_q [DEPTH];
  logic [31:0]      dict_d [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             valid_q, valid_d;
  logic [31:0]      word0_q, word0_d;
  logic [31:0]      word1_q, word1_d;
  logic             err_q, err_d;

  logic             accept;
  logic             wr0, wr1;
  logic             ill0, ill1;
  logic [IDX_W-1:0] slot1;
  logic [31:0]      dict0, dict1;
  logic [31:0]      rec0, rec1;

  function automatic logic [31:0] recon(input logic [2:0]  code,
                                        input logic [31:0] d,
                                        input logic [31:0] lit);
    case (code)
      C_XXXX:  recon = lit;
      C_MMMM:  recon = d;
      C_MMXX:  recon = {d[31:16], lit[15:0]};
      C_ZZZX:  recon = {24'd0, lit[7:0]};
      C_MMMX:  recon = {d[31:8], lit[7:0]};
      default: recon = 32'd0;
    endcase
  endfunction

  function automatic logic writes(input logic [2:0] code);
    return (code == C_XXXX) || (code == C_MMXX) || (code == C_MMMX);
  endfunction

  assign o_ready = (~valid_q | i_ready) & ~i_flush;
  assign accept  = i_valid & o_ready;

  assign wr0   = writes(i_code0);
  assign wr1   = writes(i_code1);
  assign ill0  = (i_code0 == 3'd6) || (i_code0 == 3'd7);
  assign ill1  = (i_code1 == 3'd6) || (i_code1 == 3'd7);
  assign slot1 = wr_ptr_q + IDX_W'(wr0);

  // Lane1 sees lane0's same-beat write; lane0 never sees lane1's.
  assign dict0 = dict_q[i_idx0];
  assign dict1 = (wr0 && (i_idx1 == wr_ptr_q)) ? rec0 : dict_q[i_idx1];
  assign rec0  = recon(i_code0, dict0, i_lit0);
  assign rec1  = recon(i_code1, dict1, i_lit1);

  always_comb begin
    dict_d   = dict_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    word0_d  = word0_q;
    word1_d  = word1_q;
    err_d    = err_q;

    if (i_flush) begin
      for (int i = 0; i < int'(DEPTH); i++) dict_d[i] = 32'd0;
      wr_ptr_d = '0;
    end else if (accept) begin
      if (wr0) dict_d[wr_ptr_q] = rec0;
      if (wr1) dict_d[slot1]    = rec1;
      wr_ptr_d = wr_ptr_q + IDX_W'(wr0) + IDX_W'(wr1);
    end

    if (accept) begin
      valid_d = 1'b1;
      word0_d = rec0;
      word1_d = rec1;
      if (ill0 || ill1) err_d = 1'b1;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) dict_q[i] <= 32'd0;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      word0_q  <= 32'd0;
      word1_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) dict_q[i] <= dict_d[i];
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      word0_q  <= word0_d;
      word1_q  <= word1_d;
      err_q    <= err_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_word0  = word0_q;
  assign o_word1  = word1_q;
  assign o_wr_ptr = wr_ptr_q;
  assign o_err    = err_q;

endmodule
